// File: rtl/traffic_monitor.sv
// traffic_monitor: checks lamp/phase ordering and 7-segment countdown of a traffic-light controller
module traffic_monitor #(
  parameter int GLITCH_CYCLES = 2,
  parameter int HOLD_MAX      = 150_000_000
) (
  input  logic        clk_in,
  input  logic        rst,
  input  logic        red,
  input  logic        green,
  input  logic        yellow,
  input  logic [6:0]  seg_ones,
  input  logic        one,
  input  logic        clr,
  output logic [1:0]  phase,
  output logic [3:0]  digit,
  output logic        digit_valid,
  output logic        err_lamp,
  output logic        err_seq,
  output logic        err_seg,
  output logic        err_count,
  output logic        any_err,
  output logic [15:0] transitions
);
  typedef enum logic [1:0] {SYNC, GREEN, YELLOW, RED} state_t;
  localparam int GW = $clog2(GLITCH_CYCLES + 2);
  localparam int HW = $clog2(HOLD_MAX + 2);
  logic          red_q, green_q, yellow_q, one_q, clr_q;
  logic [6:0]    seg_q;
  state_t        state, state_n, obs, last_ph;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [HW-1:0] hcnt, hcnt_n;
  logic [3:0]    dec;
  logic          seg_ok, dval, none, moved, legal, chg;
  logic          lamp_set, seq_set, seg_set, cnt_set;
  always_comb begin
    dec    = 4'd0;
    seg_ok = 1'b1;
    case (seg_q)
      7'h3F: dec = 4'd0;
      7'h06: dec = 4'd1;
      7'h5B: dec = 4'd2;
      7'h4F: dec = 4'd3;
      7'h66: dec = 4'd4;
      7'h6D: dec = 4'd5;
      7'h7D: dec = 4'd6;
      7'h07: dec = 4'd7;
      7'h7F: dec = 4'd8;
      7'h6F: dec = 4'd9;
      default: seg_ok = 1'b0;
    endcase
  end
  always_comb begin
    obs = {red_q, yellow_q, green_q} == 3'b001 ? GREEN :
          {red_q, yellow_q, green_q} == 3'b010 ? YELLOW :
          {red_q, yellow_q, green_q} == 3'b100 ? RED : SYNC;
    none    = obs == SYNC;
    state_n = none ? state : obs;
    moved   = state != SYNC && !none && obs != state;
    legal   = moved && ((state == GREEN && obs == YELLOW) ||
                        (state == YELLOW && obs == RED) ||
                        (state == RED && obs == GREEN));
    seq_set = moved && !legal;
    // lamp glitches only matter once a phase has been established
    gcnt_n   = (none && state != SYNC) ? (gcnt > GW'(GLITCH_CYCLES) ? gcnt : gcnt + GW'(1)) : '0;
    lamp_set = gcnt_n > GW'(GLITCH_CYCLES);
    dval     = one_q && seg_ok;
    seg_set  = one_q && !seg_ok;
    chg      = dval && dec != digit;
    hcnt_n   = (chg || state_n != state || state == SYNC) ? '0 :
               (hcnt > HW'(HOLD_MAX) ? hcnt : hcnt + HW'(1));
    // a phase change since the last valid digit makes any digit a legal reload
    cnt_set  = (chg && state_n != SYNC && state_n == last_ph && dec != digit - 4'd1) ||
               hcnt_n > HW'(HOLD_MAX);
  end
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      {red_q, green_q, yellow_q, one_q, clr_q} <= '0;
      seg_q       <= '0;
      state       <= SYNC;
      last_ph     <= SYNC;
      gcnt        <= '0;
      hcnt        <= '0;
      digit       <= '0;
      digit_valid <= 1'b0;
      err_lamp    <= 1'b0;
      err_seq     <= 1'b0;
      err_seg     <= 1'b0;
      err_count   <= 1'b0;
      transitions <= '0;
    end else begin
      {red_q, green_q, yellow_q, one_q, clr_q} <= {red, green, yellow, one, clr};
      seg_q       <= seg_ones;
      state       <= state_n;
      gcnt        <= gcnt_n;
      hcnt        <= hcnt_n;
      digit_valid <= dval;
      if (dval) begin
        digit   <= dec;
        last_ph <= state_n;
      end
      err_lamp    <= lamp_set | (err_lamp & ~clr_q);
      err_seq     <= seq_set | (err_seq & ~clr_q);
      err_seg     <= seg_set | (err_seg & ~clr_q);
      err_count   <= cnt_set | (err_count & ~clr_q);
      transitions <= clr_q ? {15'd0, legal} :
                     (legal && transitions != 16'hFFFF) ? transitions + 16'd1 : transitions;
    end
  end
  assign phase   = state;
  assign any_err = err_lamp | err_seq | err_seg | err_count;
endmodule

// File: tb/tb_traffic_monitor.sv
// tb_traffic_monitor: directed checks of traffic_monitor with a short hold limit
module tb_traffic_monitor;
  logic        clk_in = 1'b0, rst = 1'b0;
  logic        red = 1'b0, green = 1'b0, yellow = 1'b0, one = 1'b0, clr = 1'b0;
  logic [6:0]  seg_ones = '0;
  logic [1:0]  phase;
  logic [3:0]  digit;
  logic        digit_valid, err_lamp, err_seq, err_seg, err_count, any_err;
  logic [15:0] transitions;
  logic [6:0]  seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int          tests = 0, fails = 0;

  traffic_monitor #(.GLITCH_CYCLES(2), .HOLD_MAX(10)) dut (
    .clk_in(clk_in), .rst(rst), .red(red), .green(green), .yellow(yellow),
    .seg_ones(seg_ones), .one(one), .clr(clr), .phase(phase), .digit(digit),
    .digit_valid(digit_valid), .err_lamp(err_lamp), .err_seq(err_seq), .err_seg(err_seg),
    .err_count(err_count), .any_err(any_err), .transitions(transitions)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic drive(input logic r, input logic g, input logic y, input int d, input logic o);
    {red, green, yellow, one} = {r, g, y, o};
    seg_ones = (d < 0) ? 7'h00 : seg_tab[d];
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(1);
  endtask

  initial begin
    drive(0, 1, 0, 9, 1);
    cyc(2);
    chk("rst_phase", 16'(phase), 16'd0);
    chk("rst_digit", 16'(digit), 16'd0);
    chk("rst_dv", 16'(digit_valid), 16'd0);
    chk("rst_err", 16'(any_err), 16'd0);
    chk("rst_trans", transitions, 16'd0);
    rst = 1'b1;
    cyc(3);
    chk("sync_phase", 16'(phase), 16'd1);
    chk("sync_digit", 16'(digit), 16'd9);
    chk("sync_dv", 16'(digit_valid), 16'd1);
    chk("sync_err", 16'({err_lamp, err_seq, err_seg, err_count}), 16'd0);
    chk("sync_trans", transitions, 16'd0);

    for (int d = 8; d >= 0; d--) begin drive(0, 1, 0, d, 1); cyc(2); end
    for (int d = 3; d >= 0; d--) begin drive(0, 0, 1, d, 1); cyc(2); end
    chk("yel_phase", 16'(phase), 16'd2);
    for (int d = 9; d >= 0; d--) begin drive(1, 0, 0, d, 1); cyc(2); end
    chk("red_phase", 16'(phase), 16'd3);
    drive(0, 1, 0, 9, 1);
    cyc(2);
    chk("cycle_trans", transitions, 16'd3);
    chk("cycle_err", 16'(any_err), 16'd0);
    chk("cycle_phase", 16'(phase), 16'd1);

    for (int d = 8; d >= 5; d--) begin drive(0, 1, 0, d, 1); cyc(2); end
    chk("step_ok", 16'(err_count), 16'd0);
    drive(0, 1, 0, 3, 1);
    cyc(2);
    chk("step_bad", 16'(err_count), 16'd1);
    chk("step_digit", 16'(digit), 16'd3);
    drive(0, 1, 0, 1, 1);
    pulse_clr();
    chk("clr_vs_set", 16'(err_count), 16'd1);
    pulse_clr();
    chk("clr_alone", 16'(any_err), 16'd0);

    drive(1, 0, 0, 9, 1);
    cyc(2);
    chk("g2r_seq", 16'(err_seq), 16'd1);
    chk("g2r_phase", 16'(phase), 16'd3);
    chk("g2r_trans", transitions, 16'd0);
    chk("g2r_reload", 16'(err_count), 16'd0);
    pulse_clr();
    chk("g2r_clr", 16'(any_err), 16'd0);

    drive(1, 1, 0, 8, 1);
    cyc(2);
    drive(1, 0, 0, 8, 1);
    cyc(2);
    chk("glitch2_lamp", 16'(err_lamp), 16'd0);
    chk("glitch2_err", 16'(any_err), 16'd0);
    drive(1, 1, 0, 7, 1);
    cyc(4);
    chk("glitch3_lamp", 16'(err_lamp), 16'd1);
    chk("glitch3_phase", 16'(phase), 16'd3);
    drive(1, 0, 0, 6, 1);
    cyc(2);

    drive(1, 0, 0, -1, 1);
    pulse_clr();
    chk("seg_err", 16'(err_seg), 16'd1);
    chk("seg_dv", 16'(digit_valid), 16'd0);
    chk("seg_hold", 16'(digit), 16'd6);
    chk("seg_lampclr", 16'(err_lamp), 16'd0);
    drive(1, 0, 0, -1, 0);
    pulse_clr();
    chk("seg_off_err", 16'(any_err), 16'd0);
    chk("seg_off_dv", 16'(digit_valid), 16'd0);

    drive(1, 0, 0, 5, 1);
    cyc(10);
    chk("hold_short", 16'(err_count), 16'd0);
    cyc(4);
    chk("hold_long", 16'(err_count), 16'd1);
    chk("hold_any", 16'(any_err), 16'd1);

    #2 rst = 1'b0;
    #1;
    chk("mid_rst_err", 16'(any_err), 16'd0);
    chk("mid_rst_phase", 16'(phase), 16'd0);
    drive(0, 0, 1, 3, 1);
    cyc(1);
    rst = 1'b1;
    cyc(3);
    chk("resync_phase", 16'(phase), 16'd2);
    chk("resync_err", 16'(any_err), 16'd0);
    chk("resync_trans", transitions, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule
